// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the Dmem load/store unit
//
// Purpose: access-size and FSM-state enums, the data width, and the request
//          error check shared by the LSU top and its lane-align helper.
// Ports:   none (package).

package lsu_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Alignment/size legality of a request; the address-range test depends
  // on AW and is done by the caller.
  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo;
      SZ_X:    bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend and store merge
//
// Purpose: combinational datapath. For loads, selects the addressed byte or
//          half of the Dmem word and sign/zero extends it. For stores, splices
//          the low byte/half of the store data into the previously read word.
// Ports:
//   size        in   access size (byte/half/word)
//   is_unsigned in   1 = zero-extend loads
//   lane        in   byte address bits [1:0]
//   word        in   word read from Dmem
//   wdata       in   right-aligned store data
//   load_data   out  extracted/extended load value
//   merged      out  word to write back to Dmem

module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e             size,
  input  logic              is_unsigned,
  input  logic [1:0]        lane,
  input  logic [DW-1:0]     word,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     load_data,
  output logic [DW-1:0]     merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    case (size)
      SZ_B:    load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Only the addressed lane changes; the remaining bytes keep the read value.
  always_comb begin
    merged = word;
    case (size)
      SZ_B: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      SZ_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store initiator for the word-only Dmem port
//
// Purpose: accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests, checks
//          them, and drives Dmem. Sub-word stores are read-modify-write.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   req_valid_i / req_ready_o          request handshake
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i  request
//   rsp_valid_o, rsp_err_o, rsp_rdata_o  one-cycle completion
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i  Dmem port

module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [31:0]     req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  output logic            rsp_err_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  state_e          state_q, state_d;
  logic            we_q, uns_q, err_q;
  size_e           size_q;
  logic [AW+1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   word_q;
  logic            accept;
  logic            req_err;
  logic [DW-1:0]   load_data;
  logic [DW-1:0]   merged;

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign req_err     = bad_align(req_size_i, req_addr_i[1:0]) || (|req_addr_i[31:AW+2]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)
            state_d = RESP;
          else if (req_we_i && (req_size_i == SZ_W))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        err_q   <= req_err;
        size_q  <= size_e'(req_size_i);
        addr_q  <= req_addr_i[AW+1:0];
        wdata_q <= req_wdata_i;
      end
      if (state_q == RD)
        word_q <= mem_rdata_i;
    end
  end

  lsu_lane_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lane        (addr_q[1:0]),
    .word        (word_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Strobes are gated by rst_i so an abandoned transfer can neither write
  // Dmem nor signal completion in the reset cycle itself.
  assign mem_we_o    = (state_q == WR) && !rst_i;
  assign mem_addr_o  = addr_q[AW+1:2];
  assign mem_wdata_o = (state_q == WR) ? merged : '0;
  assign rsp_valid_o = (state_q == RESP) && !rst_i;
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed, table-driven bench for dmem_lsu

module tb_dmem_lsu;

  localparam int AW = 5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  dmem_lsu #(.AW(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_err_o      (rsp_err_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // Dmem model: combinational read, write on rising edge; preload port for setup.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_idx = '0;
  logic [31:0]   pl_val = '0;
  int            wr_count = 0;

  assign mem_rdata_i = mem[mem_addr_o];

  always @(posedge clk_i) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_we_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
      wr_count <= wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] idx, input logic [31:0] val);
    @(negedge clk_i);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wecnt;
    int          widx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [16];

  // Issues one request from a negedge and observes cycles c1.. until rsp_valid_o.
  task automatic run_req(input vec_t v, output int lat, output logic err,
                         output logic [31:0] rd, output int wecnt, output int wecyc,
                         output logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    req_we_i = v.we; req_size_i = v.size; req_unsigned_i = v.uns;
    req_addr_i = v.addr; req_wdata_i = v.wdata; req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    lat = -1; err = 1'b0; rd = '0; wecnt = 0; wecyc = -1; wd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (mem_we_o) begin
        wecnt++;
        wecyc = c;
        wd = mem_wdata_o;
      end
      if (rsp_valid_o) begin
        lat = c;
        err = rsp_err_o;
        rd = rsp_rdata_o;
        break;
      end
    end
  endtask

  initial begin
    int lat, wecnt, wecyc, r1, r2, ready_low, wr0, rsp_seen;
    logic err;
    logic [31:0] rd, wd, rd2;

    //             we  size   uns addr      wdata         rdata         err lat wecnt widx word
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hA5A5A5A5, 32'h0,        1'b0, 2, 1,  2, 32'hA5A5A5A5};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h07, 32'h0,        32'h00000012, 1'b0, 2, 0, -1, 32'h0};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h04, 32'h0,        32'h00005678, 1'b0, 2, 0, -1, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h05, 32'h0,        32'h00000056, 1'b0, 2, 0, -1, 32'h0};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,        32'hFFFF8765, 1'b0, 2, 0, -1, 32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,        32'h00008765, 1'b0, 2, 0, -1, 32'h0};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h0C, 32'h0,        32'h00000021, 1'b0, 2, 0, -1, 32'h0};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0F, 32'h0,        32'hFFFFFF87, 1'b0, 2, 0, -1, 32'h0};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h01, 32'hFFFFFF3C, 32'h0,        1'b0, 3, 1,  0, 32'hA5A53CA5};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h02, 32'h00001234, 32'h0,        1'b0, 3, 1,  0, 32'h12343CA5};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'h12343CA5, 1'b0, 2, 0, -1, 32'h0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0C, 32'hFFFFABCD, 32'h0,        1'b0, 3, 1,  3, 32'h8765ABCD};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};
    vecs[14] = '{1'b1, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};

    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;

    preload(5'd0, 32'hA5A5A5A5);
    preload(5'd1, 32'h12345678);
    preload(5'd3, 32'h87654321);
    preload(5'd8, 32'h11223344);

    @(negedge clk_i);
    chk("reset_ready_low", {31'b0, req_ready_o}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("reset_mem_we", {31'b0, mem_we_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ready", {31'b0, req_ready_o}, 32'd1);
    chk("idle_mem_addr", {27'b0, mem_addr_o}, 32'd0);
    chk("idle_mem_wdata", mem_wdata_o, 32'd0);
    chk("idle_rsp_rdata", rsp_rdata_o, 32'd0);

    for (int i = 0; i < 16; i++) begin
      wr0 = wr_count;
      run_req(vecs[i], lat, err, rd, wecnt, wecyc, wd);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_we_pulses", i), wecnt, vecs[i].exp_wecnt);
      chk($sformatf("v%0d_writes", i), wr_count - wr0, vecs[i].exp_wecnt);
      if (vecs[i].widx >= 0) begin
        chk($sformatf("v%0d_we_cycle", i), wecyc, vecs[i].exp_lat - 1);
        chk($sformatf("v%0d_mem_wdata", i), wd, vecs[i].exp_word);
        chk($sformatf("v%0d_mem_word", i), mem[vecs[i].widx], vecs[i].exp_word);
      end
    end
    // Words not addressed by any store remain intact.
    chk("mem1_untouched", mem[1], 32'h12345678);

    // Back-to-back: valid held high, SW then LW to the same address.
    @(negedge clk_i);
    req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h10; req_wdata_i = 32'hDEADBEEF; req_valid_i = 1'b1;
    chk("b2b_ready_at_issue", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1 req_we_i = 1'b0; req_wdata_i = 32'h0;
    r1 = -1; r2 = -1; rd2 = '0; ready_low = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if ((c == 1 || c == 2) && !req_ready_o) ready_low++;
      if (c == 3) chk("b2b_ready_after_resp", {31'b0, req_ready_o}, 32'd1);
      if (rsp_valid_o) begin
        if (r1 < 0) r1 = c;
        else begin
          r2 = c;
          rd2 = rsp_rdata_o;
        end
      end
      if (c == 4) req_valid_i = 1'b0;
      if (r2 >= 0) break;
    end
    chk("b2b_ready_low_busy", ready_low, 2);
    chk("b2b_first_rsp", r1, 2);
    chk("b2b_second_rsp", r2, 5);
    chk("b2b_load_value", rd2, 32'hDEADBEEF);
    chk("b2b_mem_word", mem[4], 32'hDEADBEEF);

    // Reset during the WR cycle of an SB: the write and response are abandoned.
    @(negedge clk_i);
    wr0 = wr_count;
    req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h20; req_wdata_i = 32'h000000FF; req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_wr_merged_word", mem_wdata_o, 32'h112233FF);
    chk("rst_wr_no_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_wr_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready_after", {31'b0, req_ready_o}, 32'd1);
    rsp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid_o) rsp_seen++;
      @(negedge clk_i);
    end
    chk("rst_no_rsp_later", rsp_seen, 0);
    chk("rst_no_write", wr_count - wr0, 0);
    chk("rst_mem_intact", mem[8], 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
